// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC parallel-bus controller.
package rtc_bus_pkg;

  localparam int CNT_W = 4;

  localparam int T_SETUP_DEF = 2;
  localparam int T_PULSE_DEF = 4;
  localparam int T_HOLD_DEF  = 2;
  localparam int T_GAP_DEF   = 3;

  localparam logic       CS_IDLE  = 1'b1;
  localparam logic       RD_IDLE  = 1'b1;
  localparam logic       WR_IDLE  = 1'b1;
  localparam logic       AD_IDLE  = 1'b0;
  localparam logic [7:0] BUS_IDLE = 8'h00;

  typedef enum logic [3:0] {
    IDLE, A_SETUP, A_STROBE, A_HOLD, GAP, D_SETUP, D_STROBE, D_HOLD, DONE
  } state_t;

  // Counter preload for a phase lasting 'cycles' clocks (expires on the last one).
  function automatic logic [CNT_W-1:0] phase_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/rtc_bus_ctrl_phase_timer.sv
// Load/decrement phase counter; expire pulses in the last cycle of a loaded phase.
module phase_timer
  import rtc_bus_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;
  logic             active;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (load) begin
      cnt    <= load_val;
      active <= 1'b1;
    end else if (expire) begin
      active <= 1'b0;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = active && (cnt == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Sequences one address phase and one data phase on the multiplexed RTC bus per request.
// state    | meaning
// IDLE     | waiting for Acceso
// A_SETUP  | CS_n low, address driven
// A_STROBE | WR_n low latches address
// A_HOLD   | address held after strobe
// GAP      | CS_n high between phases
// D_SETUP  | CS_n low, data driven (write) or bus released (read)
// D_STROBE | WR_n or RD_n low
// D_HOLD   | bus held after strobe
// DONE     | FRW pulse
module rtc_bus_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_PULSE = T_PULSE_DEF,
  parameter int T_HOLD  = T_HOLD_DEF,
  parameter int T_GAP   = T_GAP_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Acceso,
  input  logic       Mod,
  input  logic [6:0] Dir,
  input  logic [7:0] Wdata,
  output logic [7:0] Rdata,
  output logic       FRW,
  output logic       Busy,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       A_D,
  output logic [7:0] AD_out,
  output logic       AD_oe,
  input  logic [7:0] AD_in
);

  state_t           state, state_n;
  logic             expire, load, accept;
  logic [CNT_W-1:0] load_val;
  logic             mod_q, mod_sel;
  logic [6:0]       dir_q, dir_sel;
  logic [7:0]       wd_q, wd_sel;
  logic             cs_nx, rd_nx, wr_nx, ad_nx, oe_nx, frw_nx;
  logic [7:0]       out_nx;

  phase_timer u_timer (
    .clk     (CLK),
    .rst     (RST),
    .load    (load),
    .load_val(load_val),
    .expire  (expire)
  );

  assign accept  = (state == IDLE) && Acceso;
  // Outputs are computed for the state being entered, so the accept edge uses live inputs.
  assign mod_sel = accept ? Mod   : mod_q;
  assign dir_sel = accept ? Dir   : dir_q;
  assign wd_sel  = accept ? Wdata : wd_q;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (Acceso) state_n = A_SETUP;
      A_SETUP:  if (expire) state_n = A_STROBE;
      A_STROBE: if (expire) state_n = A_HOLD;
      A_HOLD:   if (expire) state_n = GAP;
      GAP:      if (expire) state_n = D_SETUP;
      D_SETUP:  if (expire) state_n = D_STROBE;
      D_STROBE: if (expire) state_n = D_HOLD;
      D_HOLD:   if (expire) state_n = DONE;
      DONE:     if (expire) state_n = IDLE;
      default:  state_n = IDLE;
    endcase

    load = (state_n != state) && (state_n != IDLE);
    unique case (state_n)
      A_SETUP, D_SETUP:   load_val = phase_load(T_SETUP);
      A_STROBE, D_STROBE: load_val = phase_load(T_PULSE);
      A_HOLD, D_HOLD:     load_val = phase_load(T_HOLD);
      GAP:                load_val = phase_load(T_GAP);
      default:            load_val = phase_load(1);
    endcase

    cs_nx  = CS_IDLE;
    rd_nx  = RD_IDLE;
    wr_nx  = WR_IDLE;
    ad_nx  = AD_IDLE;
    oe_nx  = 1'b0;
    out_nx = BUS_IDLE;
    frw_nx = 1'b0;
    unique case (state_n)
      A_SETUP, A_STROBE, A_HOLD: begin
        cs_nx  = 1'b0;
        oe_nx  = 1'b1;
        out_nx = {1'b0, dir_sel};
        wr_nx  = (state_n != A_STROBE);
      end
      GAP: ad_nx = 1'b1;
      D_SETUP, D_STROBE, D_HOLD: begin
        cs_nx = 1'b0;
        ad_nx = 1'b1;
        if (mod_sel) begin
          oe_nx  = 1'b1;
          out_nx = wd_sel;
          wr_nx  = (state_n != D_STROBE);
        end else begin
          rd_nx = (state_n != D_STROBE);
        end
      end
      DONE:    frw_nx = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      mod_q  <= 1'b0;
      dir_q  <= '0;
      wd_q   <= '0;
      Rdata  <= '0;
      FRW    <= 1'b0;
      Busy   <= 1'b0;
      CS_n   <= CS_IDLE;
      RD_n   <= RD_IDLE;
      WR_n   <= WR_IDLE;
      A_D    <= AD_IDLE;
      AD_out <= BUS_IDLE;
      AD_oe  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        mod_q <= Mod;
        dir_q <= Dir;
        wd_q  <= Wdata;
      end
      if (state == D_STROBE && expire && !mod_q) Rdata <= AD_in;
      FRW    <= frw_nx;
      Busy   <= (state_n != IDLE);
      CS_n   <= cs_nx;
      RD_n   <= rd_nx;
      WR_n   <= wr_nx;
      A_D    <= ad_nx;
      AD_out <= out_nx;
      AD_oe  <= oe_nx;
    end
  end

endmodule
